// File: rtl/fwd_mux_reg.sv
// fwd_mux_reg: registered operand-select for the forwarding path.
// Picks the operand from the register file or one of NUM_SRC forwarding
// sources (lowest index = youngest stage wins), then registers the result
// into the next pipeline stage with stall (hold) and flush (bubble) control.
// Optional feature: define FWD_MUX_HIT_CNT_EN to add a 32-bit forwarded-load
// counter on output port hit_cnt.
// SELW must satisfy 2**SELW >= NUM_SRC+1 so every source index fits out_sel.
module fwd_mux_reg #(
  parameter int W       = 32,
  parameter int NUM_SRC = 2,
  parameter int RA      = 5,
  parameter int SELW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [RA-1:0]         src_reg,
  input  logic [W-1:0]          rf_data,
  input  logic [NUM_SRC-1:0]    fwd_valid,
  input  logic [NUM_SRC*RA-1:0] fwd_reg,
  input  logic [NUM_SRC*W-1:0]  fwd_data,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  output logic                  out_fwd,
  output logic [SELW-1:0]       out_sel
`ifdef FWD_MUX_HIT_CNT_EN
  ,
  output logic [31:0]           hit_cnt
`endif
);

  logic [NUM_SRC-1:0] hit;
  logic               any_hit;
  logic [W-1:0]       sel_data;
  logic [SELW-1:0]    sel_idx;
  logic               load;

  logic [W-1:0]       out_data_q,  out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_fwd_q,   out_fwd_d;
  logic [SELW-1:0]    out_sel_q,   out_sel_d;

  // Per-source match: valid writer, same register, and never register 0.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      hit[i] = fwd_valid[i] && (fwd_reg[i*RA +: RA] == src_reg) && (src_reg != '0);
    end
  end

  assign any_hit = |hit;

  // Priority select: scan oldest to youngest so the lowest hitting index wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    sel_data = rf_data;
    sel_idx  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_data = fwd_data[i*W +: W];
        sel_idx  = SELW'(i + 1);
      end
    end
  end

  // A register update happens on an edge that is neither flushed nor stalled.
  assign load = !flush && !stall;

  // Next-state for the output register: flush > stall > load.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_fwd_d   = out_fwd_q;
    out_sel_d   = out_sel_q;
    if (flush) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_fwd_d   = 1'b0;
      out_sel_d   = '0;
    end else if (!stall) begin
      out_data_d  = sel_data;
      out_valid_d = in_valid;
      out_fwd_d   = in_valid && any_hit;
      out_sel_d   = sel_idx;
    end
  end

  // Output pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_fwd_q   <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of process order.
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_fwd_q   <= out_fwd_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_fwd   = out_fwd_q;
  assign out_sel   = out_sel_q;

`ifdef FWD_MUX_HIT_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;

  // Count valid forwarded loads; holds on stall/flush, wraps naturally.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (load && in_valid && any_hit) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Testbench for fwd_mux_reg: directed vectors, scoreboard queue of expected
// registered outputs, and a negedge monitor that pops and compares.
module tb_fwd_mux_reg;

  localparam int W = 32, NUM_SRC = 2, RA = 5, SELW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stall, flush, in_valid;
  logic [RA-1:0]         src_reg;
  logic [W-1:0]          rf_data;
  logic [NUM_SRC-1:0]    fwd_valid;
  logic [NUM_SRC*RA-1:0] fwd_reg;
  logic [NUM_SRC*W-1:0]  fwd_data;
  logic [W-1:0]          out_data;
  logic                  out_valid, out_fwd;
  logic [SELW-1:0]       out_sel;
`ifdef FWD_MUX_HIT_CNT_EN
  logic [31:0]           hit_cnt;
`endif

  fwd_mux_reg #(.W(W), .NUM_SRC(NUM_SRC), .RA(RA), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .src_reg   (src_reg),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_fwd   (out_fwd),
    .out_sel   (out_sel)
`ifdef FWD_MUX_HIT_CNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        valid;
    logic        fwd;
    logic [1:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare registered outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".data"},  out_data,         e.data);
      check({e.name, ".valid"}, 32'(out_valid),   32'(e.valid));
      check({e.name, ".fwd"},   32'(out_fwd),     32'(e.fwd));
      check({e.name, ".sel"},   32'(out_sel),     32'(e.sel));
    end
  end

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic step(input string name, input logic v, input logic [4:0] src,
                      input logic [31:0] rf, input logic [1:0] fv,
                      input logic [4:0] fr0, input logic [31:0] fd0,
                      input logic [4:0] fr1, input logic [31:0] fd1,
                      input logic st, input logic fl,
                      input logic [31:0] e_data, input logic e_valid,
                      input logic e_fwd, input logic [1:0] e_sel);
    exp_t e;
    in_valid  = v;
    src_reg   = src;
    rf_data   = rf;
    fwd_valid = fv;
    fwd_reg   = {fr1, fr0};
    fwd_data  = {fd1, fd0};
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
    e.name = name; e.data = e_data; e.valid = e_valid; e.fwd = e_fwd; e.sel = e_sel;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the monitor to drain the scoreboard.
  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; in_valid = 0; src_reg = '0;
    rf_data = '0; fwd_valid = '0; fwd_reg = '0; fwd_data = '0;
    #22;
    check("reset.data",  out_data,       32'd0);
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.fwd",   32'(out_fwd),   32'd0);
    check("reset.sel",   32'(out_sel),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //    name           v src rf            fv     fr0 fd0            fr1 fd1            st fl  exp_data     ev ef es
    step("no_match",     1, 5, 32'h11111111, 2'b00, 0,  32'h0,         0,  32'h0,         0, 0,  32'h11111111, 1, 0, 0);
    step("prio_both",    1, 7, 32'h22222222, 2'b11, 7,  32'hAAAA0000,  7,  32'hBBBB0000,  0, 0,  32'hAAAA0000, 1, 1, 1);
    step("prio_src1",    1, 7, 32'h22222222, 2'b10, 7,  32'hAAAA0000,  7,  32'hBBBB0000,  0, 0,  32'hBBBB0000, 1, 1, 2);
    step("reg_zero",     1, 0, 32'h0,        2'b01, 0,  32'hDEADBEEF,  0,  32'h0,         0, 0,  32'h0,        1, 0, 0);
    step("load_fwd1",    1, 3, 32'h0,        2'b10, 4,  32'hFFFF0000,  3,  32'h12345678,  0, 0,  32'h12345678, 1, 1, 2);
    step("stall_1",      1, 8, 32'h33333333, 2'b01, 8,  32'h44444444,  0,  32'h0,         1, 0,  32'h12345678, 1, 1, 2);
    step("stall_2",      0, 9, 32'h55555555, 2'b00, 0,  32'h0,         0,  32'h0,         1, 0,  32'h12345678, 1, 1, 2);
    step("stall_3",      1, 2, 32'h66666666, 2'b11, 2,  32'h77777777,  2,  32'h88888888,  1, 0,  32'h12345678, 1, 1, 2);
    step("stall_flush",  1, 2, 32'h66666666, 2'b11, 2,  32'h77777777,  2,  32'h88888888,  1, 1,  32'h0,        0, 0, 0);
    step("invalid_hit",  0, 9, 32'h0,        2'b01, 9,  32'hCAFEF00D,  0,  32'h0,         0, 0,  32'hCAFEF00D, 0, 0, 1);
    step("reg_mismatch", 1, 6, 32'h99999999, 2'b11, 5,  32'hABCDEF01,  6,  32'h0BADF00D,  0, 0,  32'h0BADF00D, 1, 1, 2);
    step("flush_only",   1, 6, 32'h99999999, 2'b11, 6,  32'hABCDEF01,  6,  32'h0BADF00D,  0, 1,  32'h0,        0, 0, 0);
    step("rf_after",     1, 1, 32'h55AA55AA, 2'b01, 2,  32'h12121212,  0,  32'h0,         0, 0,  32'h55AA55AA, 1, 0, 0);
    drain();

    // Asynchronous reset mid-cycle with non-zero outputs held.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.data",  out_data,       32'd0);
    check("async_rst.valid", 32'(out_valid), 32'd0);
    check("async_rst.fwd",   32'(out_fwd),   32'd0);
    check("async_rst.sel",   32'(out_sel),   32'd0);
    #2;
    rst_n = 1'b1;
    step("post_rst_bub", 0, 0, 32'h0,        2'b00, 0,  32'h0,         0,  32'h0,         0, 0,  32'h0,        0, 0, 0);
    drain();

`ifdef FWD_MUX_HIT_CNT_EN
    check("hit_cnt.after_rst", hit_cnt, 32'd0);
    step("cnt_hit_1",  1, 4, 32'h0, 2'b01, 4, 32'h00000001, 0, 32'h0, 0, 0, 32'h00000001, 1, 1, 1);
    step("cnt_hit_2",  1, 4, 32'h0, 2'b10, 0, 32'h0, 4, 32'h00000002, 0, 0, 32'h00000002, 1, 1, 2);
    step("cnt_hit_3",  1, 4, 32'h0, 2'b11, 4, 32'h00000003, 4, 32'h0, 0, 0, 32'h00000003, 1, 1, 1);
    step("cnt_hit_4",  1, 4, 32'h0, 2'b01, 4, 32'h00000004, 0, 32'h0, 0, 0, 32'h00000004, 1, 1, 1);
    step("cnt_stall",  1, 4, 32'h0, 2'b01, 4, 32'h000000FF, 0, 32'h0, 1, 0, 32'h00000004, 1, 1, 1);
    step("cnt_flush",  1, 4, 32'h0, 2'b01, 4, 32'h000000FF, 0, 32'h0, 0, 1, 32'h0,        0, 0, 0);
    step("cnt_hit_5",  1, 4, 32'h0, 2'b01, 4, 32'h00000005, 0, 32'h0, 0, 0, 32'h00000005, 1, 1, 1);
    step("cnt_hit_6",  1, 4, 32'h0, 2'b01, 4, 32'h00000006, 0, 32'h0, 0, 0, 32'h00000006, 1, 1, 1);
    drain();
    check("hit_cnt.six", hit_cnt, 32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
